expnorm_pipe: RTL and testbench
===============================

Name: expnorm_pipe

Overview:
- Pipelined, parametrised exponent normaliser for the rounder. Computes the normalised exponent en = er - lz and its increment eni = en + 1.
- Applies IEEE trap wrapping by alpha = 3·2^(W-2) when a trap is enabled, where W is the exponent width of the selected format.
- Clamps to emin when underflow is masked and the result is tiny.
- Sits between the leading-zero counter and the significand rounder. It has a valid/ready handshake and a sideband tag, so several operations can be in flight.

Parameters:
- EW, 11: exponent width of the wide (double) format; sets the output width.
- SEW, 8: exponent width of the narrow (single) format; must be < EW.
- LZW, 6: leading-zero count width.
- TAGW, 4: sideband tag width, passed through unmodified.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept this cycle
- er  in  EW+2  pre-normalisation exponent, two's complement, unbiased-overflow range
- lz  in  LZW  leading-zero count (unsigned)
- db  in  1  1 = wide format, 0 = narrow format
- ovf_en  in  1  overflow trap enabled
- ovf1  in  1  pre-rounding overflow detected
- unf_en  in  1  underflow trap enabled
- tiny  in  1  result tiny
- in_tag  in  TAGW  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- en  out  EW  normalised exponent
- eni  out  EW  normalised exponent + 1
- out_tag  out  TAGW  tag aligned with en/eni
- wrapped  out  1  alpha adjustment applied (either sign)

Behaviour:
- Reset (async, active-high):
  - Stage valids s1_v and out_valid clear immediately; all data registers go to 0.
  - in_ready = 1 as soon as rst deasserts.
  - Assertion mid-operation discards everything in flight, with no output pulse.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - A transfer occurs when in_valid & in_ready.
  - While adv = 0 both stages hold and outputs are stable.
  - Latency is 2 cycles from accepted input to out_valid.
  - Full throughput (1 per cycle) when out_ready is held high.
- Alpha per format:
  - db=1: alpha = 3<<(EW-2), i.e. 1536 for EW=11.
  - db=0: alpha = 3<<(SEW-2), i.e. 192 for SEW=8.
- Stage 1 (on transfer):
  - Register d = sext(er) - zext(lz), computed in EW+3 signed bits.
  - Register the mode code, tag, and db.
- Mode code, highest priority first:
  - CLAMP: tiny & !unf_en.
  - UNFW: tiny & unf_en → +alpha.
  - OVFW: ovf_en & ovf1 → -alpha.
  - NONE.
- Stage 2 (on adv):
  - CLAMP: en = 1, eni = 2, wrapped = 0.
  - UNFW: e = d + alpha, wrapped = 1.
  - OVFW: e = d - alpha, wrapped = 1.
  - NONE: e = d, wrapped = 0.
  - en = e[EW-1:0], eni = (e+1)[EW-1:0]; modulo-2^EW wrap, no saturation.
- Narrow-format results occupy the low SEW bits of en; upper bits are whatever the arithmetic yields, and no masking is applied.
- Bubbles: stage 2 captures s1_v into out_valid on adv. An empty stage 1 produces out_valid = 0 after the drain.
- Simultaneous accept and drain in the same cycle is legal and required for full throughput.
- No combinational path from in_valid to out_valid. The only combinational path out_ready → in_ready is the adv gate.

Decomposition:
- Package fpu_exp_pkg:
  - function alpha(width), returning 3<<(width-2).
  - Constants EMIN = 1 and EMIN1 = 2.
  - Enum norm_mode_e {NONE, OVFW, UNFW, CLAMP}.
- One sub-module, expnorm_mode_sel: combinational priority encoder from the flags to norm_mode_e. It is reused by the future exception unit.
- Arithmetic stays inline; no adder instance is required.

Test Plan:
- Plain: EW=11, db=1, er=1030, lz=3, no flags → en=1027, eni=1028, wrapped=0, out_valid exactly 2 cycles after accept.
- Overflow trap: db=1, er=2100, lz=0, ovf_en=ovf1=1 → en=564, eni=565, wrapped=1. With ovf_en=0 → en=2100 mod 2048 = 52, eni=53.
- Underflow: db=1, er=-50, lz=2, tiny=1.
  - unf_en=1 → en=1484, eni=1485, wrapped=1.
  - unf_en=0 → en=1, eni=2.
  - With ovf_en=ovf1=1 as well, CLAMP still wins.
- Narrow format: db=0, er=300, lz=1, ovf_en=ovf1=1 → en=107, eni=108. With tiny=unf_en=1 instead, er=-10, lz=0 → en=182.
- Backpressure: stream 4 tagged ops (tags 0..3) with out_ready low for cycles 3-6.
  - Outputs are held stable while out_ready is low.
  - in_ready drops.
  - All 4 results emerge in order with no loss or duplication.
- Reset mid-flight: assert rst with 2 ops in flight.
  - out_valid=0 immediately and en/eni=0.
  - After release, a new op completes with correct latency and no stale output.

Source files
------------

// File: rtl/fpu_exp_pkg.sv
// Shared exponent-path types and constants for the rounder and exception unit.
// Alpha is the IEEE trap-wrap bias 3*2^(W-2) for a W-bit exponent format.
package fpu_exp_pkg;

   localparam int EMIN  = 1;
   localparam int EMIN1 = 2;

   typedef enum logic [1:0] {
      NONE,
      OVFW,
      UNFW,
      CLAMP
   } norm_mode_e;

   function automatic int alpha(input int width);
      return 3 << (width - 2);
   endfunction

endpackage

// File: rtl/expnorm_mode_sel.sv
// Priority encoder from trap/tiny flags to the exponent adjustment mode.
// Purely combinational; no latency, no backpressure.
module expnorm_mode_sel
   import fpu_exp_pkg::*;
(
   input  logic       tiny,
   input  logic       unf_en,
   input  logic       ovf_en,
   input  logic       ovf1,
   output norm_mode_e mode
);

   always_comb begin
      mode = NONE;
      if (tiny && !unf_en) begin
         mode = CLAMP;
      end else if (tiny) begin
         mode = UNFW;
      end else if (ovf_en && ovf1) begin
         mode = OVFW;
      end
   end

endmodule

// File: rtl/expnorm_pipe.sv
// Exponent normaliser en = er - lz (+/- trap alpha, or emin clamp); 2-cycle latency.
// Valid/ready: both stages hold while out_valid & !out_ready; in_ready = !out_valid | out_ready.
module expnorm_pipe
   import fpu_exp_pkg::*;
#(
   parameter int EW   = 11,
   parameter int SEW  = 8,
   parameter int LZW  = 6,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [EW+1:0]   er,
   input  logic [LZW-1:0]  lz,
   input  logic            db,
   input  logic            ovf_en,
   input  logic            ovf1,
   input  logic            unf_en,
   input  logic            tiny,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [EW-1:0]   en,
   output logic [EW-1:0]   eni,
   output logic [TAGW-1:0] out_tag,
   output logic            wrapped
);

   localparam int DW = EW + 3;
   localparam logic [DW-1:0] ALPHA_W = DW'(alpha(EW));
   localparam logic [DW-1:0] ALPHA_N = DW'(alpha(SEW));

   logic            adv;
   norm_mode_e      mode_in;
   logic [DW-1:0]   d_in;

   logic            s1_v_q, s1_v_d;
   logic [DW-1:0]   d_q, d_d;
   norm_mode_e      mode_q, mode_d;
   logic [TAGW-1:0] tag1_q, tag1_d;
   logic            db_q, db_d;

   logic            out_valid_q, out_valid_d;
   logic [EW-1:0]   en_q, en_d;
   logic [EW-1:0]   eni_q, eni_d;
   logic [TAGW-1:0] out_tag_q, out_tag_d;
   logic            wrapped_q, wrapped_d;

   logic [DW-1:0]   alpha_sel;
   logic [DW-1:0]   e;
   logic [DW-1:0]   e1;
   logic            unused_hi;

   expnorm_mode_sel u_mode_sel (
      .tiny   (tiny),
      .unf_en (unf_en),
      .ovf_en (ovf_en),
      .ovf1   (ovf1),
      .mode   (mode_in)
   );

   assign adv      = !out_valid_q || out_ready;
   assign d_in     = {er[EW+1], er} - {{(DW-LZW){1'b0}}, lz};

   // Stage-2 arithmetic is done at full width; only the low EW bits are kept (modulo wrap).
   always_comb begin
      alpha_sel = db_q ? ALPHA_W : ALPHA_N;
      case (mode_q)
         UNFW:    e = d_q + alpha_sel;
         OVFW:    e = d_q - alpha_sel;
         default: e = d_q;
      endcase
      e1 = e + DW'(1);
   end

   assign unused_hi = ^{e[DW-1:EW], e1[DW-1:EW]};

   always_comb begin
      s1_v_d      = s1_v_q;
      d_d         = d_q;
      mode_d      = mode_q;
      tag1_d      = tag1_q;
      db_d        = db_q;
      out_valid_d = out_valid_q;
      en_d        = en_q;
      eni_d       = eni_q;
      out_tag_d   = out_tag_q;
      wrapped_d   = wrapped_q;
      if (adv) begin
         s1_v_d = in_valid;
         if (in_valid) begin
            d_d    = d_in;
            mode_d = mode_in;
            tag1_d = in_tag;
            db_d   = db;
         end
         out_valid_d = s1_v_q;
         out_tag_d   = tag1_q;
         wrapped_d   = (mode_q == UNFW) || (mode_q == OVFW);
         if (mode_q == CLAMP) begin
            en_d  = EW'(EMIN);
            eni_d = EW'(EMIN1);
         end else begin
            en_d  = e[EW-1:0];
            eni_d = e1[EW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q      <= 1'b0;
         d_q         <= '0;
         mode_q      <= NONE;
         tag1_q      <= '0;
         db_q        <= 1'b0;
         out_valid_q <= 1'b0;
         en_q        <= '0;
         eni_q       <= '0;
         out_tag_q   <= '0;
         wrapped_q   <= 1'b0;
      end else begin
         s1_v_q      <= s1_v_d;
         d_q         <= d_d;
         mode_q      <= mode_d;
         tag1_q      <= tag1_d;
         db_q        <= db_d;
         out_valid_q <= out_valid_d;
         en_q        <= en_d;
         eni_q       <= eni_d;
         out_tag_q   <= out_tag_d;
         wrapped_q   <= wrapped_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign en        = en_q;
   assign eni       = eni_q;
   assign out_tag   = out_tag_q;
   assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_expnorm_pipe.sv
// Randomised and directed bench for expnorm_pipe against an integer reference model.
module tb_expnorm_pipe;

   localparam int EW   = 11;
   localparam int SEW  = 8;
   localparam int LZW  = 6;
   localparam int TAGW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [EW+1:0]   er;
   logic [LZW-1:0]  lz;
   logic            db;
   logic            ovf_en;
   logic            ovf1;
   logic            unf_en;
   logic            tiny;
   logic [TAGW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [EW-1:0]   en;
   logic [EW-1:0]   eni;
   logic [TAGW-1:0] out_tag;
   logic            wrapped;

   typedef struct {
      int en;
      int eni;
      int wr;
      int tag;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_pop = 0;

   always #5 clk = ~clk;

   expnorm_pipe #(.EW(EW), .SEW(SEW), .LZW(LZW), .TAGW(TAGW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .er        (er),
      .lz        (lz),
      .db        (db),
      .ovf_en    (ovf_en),
      .ovf1      (ovf1),
      .unf_en    (unf_en),
      .tiny      (tiny),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .en        (en),
      .eni       (eni),
      .out_tag   (out_tag),
      .wrapped   (wrapped)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the documented rules.
   function automatic exp_t model(input int er_i, input int lz_i, input bit db_i,
                                  input bit oe, input bit o1, input bit ue, input bit ti,
                                  input int tag_i);
      exp_t r;
      int   d;
      int   a;
      int   e;
      int   mask;
      mask  = (1 << EW) - 1;
      d     = er_i - lz_i;
      a     = 3 * (2 ** ((db_i ? EW : SEW) - 2));
      r.tag = tag_i;
      r.wr  = 0;
      if (ti && !ue) begin
         r.en  = 1;
         r.eni = 2;
         return r;
      end
      if (ti) begin
         e    = d + a;
         r.wr = 1;
      end else if (oe && o1) begin
         e    = d - a;
         r.wr = 1;
      end else begin
         e = d;
      end
      r.en  = e & mask;
      r.eni = (e + 1) & mask;
      return r;
   endfunction

   task automatic rand_op();
      er     = (EW+2)'($urandom);
      lz     = LZW'($urandom_range(0, 63));
      db     = 1'($urandom);
      ovf_en = 1'($urandom);
      ovf1   = 1'($urandom);
      unf_en = 1'($urandom);
      tiny   = ($urandom_range(0, 3) == 0);
      in_tag = TAGW'($urandom);
   endtask

   // Called just after a negedge with inputs set; checks the head and records accepts.
   task automatic tick_sample(output bit acc);
      exp_t x;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
         if (q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
         end else begin
            x = q[0];
            chk("sb_en", 32'(en), x.en);
            chk("sb_eni", 32'(eni), x.eni);
            chk("sb_wrapped", 32'(wrapped), x.wr);
            chk("sb_tag", 32'(out_tag), x.tag);
            if (out_ready) begin
               void'(q.pop_front());
               n_pop++;
            end
         end
      end
      if (acc) begin
         q.push_back(model(int'($signed(er)), int'(lz), db, ovf_en, ovf1, unf_en, tiny,
                           int'(in_tag)));
      end
   endtask

   task automatic directed(input string nm, input int er_i, input int lz_i, input bit db_i,
                           input bit oe, input bit o1, input bit ue, input bit ti,
                           input int x_en, input int x_eni, input int x_wr);
      @(negedge clk);
      er        = (EW+2)'(er_i);
      lz        = LZW'(lz_i);
      db        = db_i;
      ovf_en    = oe;
      ovf1      = o1;
      unf_en    = ue;
      tiny      = ti;
      in_tag    = TAGW'(x_en);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk({nm, "_lat1_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
      chk({nm, "_lat2_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_en"}, 32'(en), x_en);
      chk({nm, "_eni"}, 32'(eni), x_eni);
      chk({nm, "_wrapped"}, 32'(wrapped), x_wr);
      chk({nm, "_tag"}, 32'(out_tag), x_en & 32'hF);
   endtask

   initial begin
      bit acc;
      int sent;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      er        = '0;
      lz        = '0;
      db        = 1'b0;
      ovf_en    = 1'b0;
      ovf1      = 1'b0;
      unf_en    = 1'b0;
      tiny      = 1'b0;
      in_tag    = '0;

      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_eni", 32'(eni), 32'd0);
      chk("rst_wrapped", 32'(wrapped), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

      directed("plain",     1030, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1027, 1028, 0);
      directed("ovf_trap",  2100, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  564,  565, 1);
      directed("ovf_notrap",2100, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,   52,   53, 0);
      directed("unf_trap",   -50, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1484, 1485, 1);
      directed("unf_clamp",  -50, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,    1,    2, 0);
      directed("clamp_prio", -50, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,    1,    2, 0);
      directed("nar_ovf",    300, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  107,  108, 1);
      directed("nar_unf",    -10, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  182,  183, 1);

      // Backpressure: 4 tagged ops, consumer stalled in cycles 3..6.
      n_pop = 0;
      sent  = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rand_op();
         in_tag    = TAGW'(sent);
         in_valid  = (sent < 4);
         out_ready = !(c >= 3 && c <= 6);
         tick_sample(acc);
         if (c == 4) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
         if (acc) sent++;
      end
      chk("bp_results", 32'(n_pop), 32'd4);
      chk("bp_queue_empty", 32'(q.size()), 32'd0);

      // Randomised traffic with random stalls.
      in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rand_op();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick_sample(acc);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = 1'b1;
         tick_sample(acc);
         if (q.size() == 0 && !out_valid) break;
      end
      chk("drain_queue_empty", 32'(q.size()), 32'd0);

      // Reset with two ops in flight.
      @(negedge clk);
      rand_op();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rand_op();
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("mid_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_en", 32'(en), 32'd0);
      chk("mid_rst_eni", 32'(eni), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      #1 chk("mid_no_stale", 32'(out_valid), 32'd0);
      directed("post_rst", 1030, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1027, 1028, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
